// File: rtl/seq_event_pkg.sv
// Shared types and constants for the windowed detection-event counter.
package seq_event_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

  localparam int DEF_CNT_W = 8;
  localparam int DEF_WIN_W = 10;

  // Largest value a width-bit unsigned counter can hold (saturation ceiling).
  function automatic logic [63:0] sat_max(input int width);
    sat_max = (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/win_timer.sv
// Free-running window timer: counts 0..WINDOW-1 while enabled and flags the last cycle.
module win_timer #(
  parameter int WIN_W  = 10,
  parameter int WINDOW = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_win_last
);

  localparam logic [WIN_W-1:0] LAST = WIN_W'(WINDOW - 1);

  logic [WIN_W-1:0] r_cnt;

  assign o_win_last = (r_cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_win_last ? '0 : r_cnt + WIN_W'(1);
    end
  end

endmodule

// File: rtl/seq_event_counter.sv
// Counts detector pulses per WINDOW-cycle window and offers each total on a valid/ready port.
// Define RISING_EDGE_COUNT_EN to count only 0->1 transitions of det_in.
module seq_event_counter
  import seq_event_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int WIN_W    = DEF_WIN_W,
  parameter int WINDOW   = 1000,
  parameter int ALARM_TH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             det_in,
  input  logic             enable,
  input  logic             clear,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_data,
  output logic             rd_sat,
  output logic             alarm,
  output logic             overrun
);

  localparam logic [63:0]      CNT_MAX_W = sat_max(CNT_W);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_MAX_W[CNT_W-1:0];
  localparam logic [63:0]      TH_W      = 64'(ALARM_TH);
  localparam logic [CNT_W-1:0] TH        = TH_W[CNT_W-1:0];
  // A threshold beyond the counter range can never be reached.
  localparam bit               TH_OK     = (TH_W <= CNT_MAX_W);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;
  logic             r_valid;
  logic [CNT_W-1:0] r_data;
  logic             r_rep_sat;
  logic             r_alarm;
  logic             r_overrun;

  logic             w_run;
  logic             w_win_last;
  logic             w_win_end;
  logic             w_hit;
  logic             w_at_max;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_sat_inc;
  logic             w_alarm;
  logic             w_load;
  logic             w_tmr_en;
  logic             w_tmr_clr;

  assign w_run     = (r_state == ST_RUN);
  assign w_tmr_en  = w_run & enable;
  assign w_tmr_clr = clear | ~w_run | ~enable;

  win_timer #(
    .WIN_W (WIN_W),
    .WINDOW(WINDOW)
  ) u_win_timer (
    .clk       (clk),
    .reset     (reset),
    .i_en      (w_tmr_en),
    .i_clr     (w_tmr_clr),
    .o_win_last(w_win_last)
  );

`ifdef RISING_EDGE_COUNT_EN
  // History survives window boundaries so a long pulse counts once, where it rose.
  logic r_det_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_det_q <= 1'b0;
    end else if (clear) begin
      r_det_q <= 1'b0;
    end else begin
      r_det_q <= det_in;
    end
  end

  assign w_hit = det_in & ~r_det_q;
`else
  assign w_hit = det_in;
`endif

  assign w_at_max  = (r_cnt == CNT_MAX);
  assign w_cnt_inc = (w_hit & ~w_at_max) ? r_cnt + CNT_W'(1) : r_cnt;
  assign w_sat_inc = r_sat | (w_hit & w_at_max);
  assign w_alarm   = TH_OK && (w_cnt_inc >= TH);

  // The last window cycle's own det_in is folded into the reported total.
  assign w_win_end = w_run & w_win_last & ~clear;
  assign w_load    = w_win_end & (~r_valid | rd_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else if (clear) begin
      r_state <= enable ? ST_RUN : ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (enable)  r_state <= ST_RUN;
        ST_RUN:  if (!enable) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (clear || !w_run || !enable || w_win_last) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else begin
      r_cnt <= w_cnt_inc;
      r_sat <= w_sat_inc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_rep_sat <= 1'b0;
      r_alarm   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (clear) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_rep_sat <= 1'b0;
      r_alarm   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_load) begin
      r_valid   <= 1'b1;
      r_data    <= w_cnt_inc;
      r_rep_sat <= w_sat_inc;
      r_alarm   <= w_alarm;
    end else if (w_win_end) begin
      // Consumer still holds the previous report: drop the new one.
      r_overrun <= 1'b1;
    end else if (r_valid && rd_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign rd_valid = r_valid;
  assign rd_data  = r_data;
  assign rd_sat   = r_rep_sat;
  assign alarm    = r_alarm;
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_seq_event_counter.sv
// Directed bench for seq_event_counter with WINDOW=8, CNT_W=3, ALARM_TH=3.
module tb_seq_event_counter;

  localparam int CNT_W    = 3;
  localparam int WIN_W    = 4;
  localparam int WINDOW   = 8;
  localparam int ALARM_TH = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             det_in;
  logic             enable;
  logic             clear;
  logic             rd_ready;
  logic             rd_valid;
  logic [CNT_W-1:0] rd_data;
  logic             rd_sat;
  logic             alarm;
  logic             overrun;

  logic [6:0] obs;
  logic [6:0] exp_v;
  int         checks = 0;
  int         errors = 0;
  int         v;

  assign obs = {rd_valid, rd_data, rd_sat, alarm, overrun};

  always #5 clk = ~clk;

  seq_event_counter #(
    .CNT_W   (CNT_W),
    .WIN_W   (WIN_W),
    .WINDOW  (WINDOW),
    .ALARM_TH(ALARM_TH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .det_in  (det_in),
    .enable  (enable),
    .clear   (clear),
    .rd_ready(rd_ready),
    .rd_valid(rd_valid),
    .rd_data (rd_data),
    .rd_sat  (rd_sat),
    .alarm   (alarm),
    .overrun (overrun)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  // Events the counter should see for an 8-cycle det_in pattern (bit 0 first).
  function automatic int exp_hits(input logic [7:0] pat, input logic prev);
    int   n = 0;
    logic p = prev;
    for (int i = 0; i < 8; i++) begin
`ifdef RISING_EDGE_COUNT_EN
      if (pat[i] && !p) n++;
`else
      if (pat[i]) n++;
`endif
      p = pat[i];
    end
    return n;
  endfunction

  // {data, sat, alarm} for a window that saw 'hits' events.
  function automatic logic [4:0] exp_rep(input int hits);
    int         d = (hits > 7) ? 7 : hits;
    logic [2:0] dv = 3'(d);
    return {dv, (hits > 7), (d >= ALARM_TH)};
  endfunction

  task automatic run_window(input logic [7:0] pat, input logic rdy, input logic rdy_last,
                            output int vcnt);
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      det_in   = pat[i];
      rd_ready = (i == 7) ? rdy_last : rdy;
      tick();
      if (i < 7 && rd_valid) vcnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; det_in = 1'b0; clear = 1'b0; rd_ready = 1'b0;
    repeat (2) tick();
    checks++;
    if (obs !== 7'b0) begin
      errors++; $display("FAIL reset_state: got %b expected %b", obs, 7'b0);
    end
    reset = 1'b1; enable = 1'b1; rd_ready = 1'b1;
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++; $display("FAIL idle_to_run_valid: got %b expected 0", rd_valid);
    end
  endtask

  task automatic test_basic();
    run_window(8'b0000_1101, 1'b1, 1'b1, v);
    exp_v = {1'b1, exp_rep(exp_hits(8'b0000_1101, 1'b0)), 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL basic_report: got %b expected %b", obs, exp_v);
    end
    checks++;
    if (v !== 0) begin
      errors++; $display("FAIL basic_early_valid: got %0d expected 0", v);
    end
    $display("window report basic: valid=%b data=%0d sat=%b alarm=%b", rd_valid, rd_data, rd_sat, alarm);

    run_window(8'hFF, 1'b1, 1'b1, v);
    checks++;
    if (v !== 0) begin
      errors++; $display("FAIL one_cycle_valid: got %0d expected 0", v);
    end
    exp_v = {1'b1, exp_rep(exp_hits(8'hFF, 1'b0)), 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL sat_report: got %b expected %b", obs, exp_v);
    end
    $display("window report sat: valid=%b data=%0d sat=%b alarm=%b", rd_valid, rd_data, rd_sat, alarm);

    run_window(8'h00, 1'b1, 1'b1, v);
    exp_v = {1'b1, exp_rep(exp_hits(8'h00, 1'b1)), 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL zero_report: got %b expected %b", obs, exp_v);
    end
    $display("window report zero: valid=%b data=%0d sat=%b alarm=%b", rd_valid, rd_data, rd_sat, alarm);
  endtask

  task automatic test_overrun();
    clear = 1'b1; det_in = 1'b0; rd_ready = 1'b0;
    tick();
    clear = 1'b0;
    checks++;
    if (obs !== 7'b0) begin
      errors++; $display("FAIL clear_outputs: got %b expected %b", obs, 7'b0);
    end
    run_window(8'b0000_0011, 1'b0, 1'b0, v);
    exp_v = {1'b1, exp_rep(exp_hits(8'b0000_0011, 1'b0)), 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL overrun_first: got %b expected %b", obs, exp_v);
    end
    run_window(8'b0001_1111, 1'b0, 1'b0, v);
    exp_v[0] = 1'b1;
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL overrun_kept: got %b expected %b", obs, exp_v);
    end
    checks++;
    if (v !== 7) begin
      errors++; $display("FAIL overrun_valid_held: got %0d expected 7", v);
    end
    $display("window report overrun: valid=%b data=%0d overrun=%b", rd_valid, rd_data, overrun);
    rd_ready = 1'b1; det_in = 1'b0;
    tick();
    checks++;
    if ({rd_valid, overrun} !== 2'b01) begin
      errors++; $display("FAIL handshake_drop: got %b expected 01", {rd_valid, overrun});
    end
    rd_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_sticky: got %b expected 1", overrun);
    end
  endtask

  task automatic test_back_to_back();
    clear = 1'b1; det_in = 1'b0; rd_ready = 1'b0;
    tick();
    clear = 1'b0;
    checks++;
    if (obs !== 7'b0) begin
      errors++; $display("FAIL clear_overrun: got %b expected %b", obs, 7'b0);
    end
    run_window(8'b0000_0001, 1'b0, 1'b0, v);
    exp_v = {1'b1, exp_rep(exp_hits(8'b0000_0001, 1'b0)), 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL b2b_first: got %b expected %b", obs, exp_v);
    end
    run_window(8'b0000_1111, 1'b0, 1'b1, v);
    checks++;
    if (v !== 7) begin
      errors++; $display("FAIL b2b_valid_held: got %0d expected 7", v);
    end
    exp_v = {1'b1, exp_rep(exp_hits(8'b0000_1111, 1'b0)), 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL b2b_reload: got %b expected %b", obs, exp_v);
    end
    $display("window report b2b: valid=%b data=%0d alarm=%b overrun=%b", rd_valid, rd_data, alarm, overrun);
  endtask

  task automatic test_async_reset();
    rd_ready = 1'b0; det_in = 1'b1;
    repeat (2) tick();
    checks++;
    if (rd_valid !== 1'b1) begin
      errors++; $display("FAIL pre_reset_valid: got %b expected 1", rd_valid);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (obs !== 7'b0) begin
      errors++; $display("FAIL async_reset: got %b expected %b", obs, 7'b0);
    end
    tick();
    reset = 1'b1; det_in = 1'b0; rd_ready = 1'b1;
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_valid: got %b expected 0", rd_valid);
    end
    run_window(8'b1010_1010, 1'b1, 1'b1, v);
    checks++;
    if (v !== 0) begin
      errors++; $display("FAIL post_reset_early: got %0d expected 0", v);
    end
    exp_v = {1'b1, exp_rep(exp_hits(8'b1010_1010, 1'b0)), 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL post_reset_report: got %b expected %b", obs, exp_v);
    end
    $display("window report after reset: valid=%b data=%0d alarm=%b", rd_valid, rd_data, alarm);
  endtask

  task automatic test_level_vs_edge();
    clear = 1'b1; det_in = 1'b0; rd_ready = 1'b1;
    tick();
    clear = 1'b0;
    run_window(8'hFF, 1'b1, 1'b1, v);
    exp_v = {1'b1, exp_rep(exp_hits(8'hFF, 1'b0)), 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL held_first: got %b expected %b", obs, exp_v);
    end
    $display("window report held 1: data=%0d sat=%b", rd_data, rd_sat);
    run_window(8'hFF, 1'b1, 1'b1, v);
    exp_v = {1'b1, exp_rep(exp_hits(8'hFF, 1'b1)), 1'b0};
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL held_second: got %b expected %b", obs, exp_v);
    end
    $display("window report held 2: data=%0d sat=%b", rd_data, rd_sat);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_back_to_back();
    test_async_reset();
    test_level_vs_edge();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
